// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: receive-only UART monitor (8 data bits, LSB first, 1 stop bit).
// The serial line passes through a 2-flop synchronizer. Each byte is decoded, and
// framing errors (and optionally parity errors) are flagged. Good bytes are counted.
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit after
// data bit 7. Without the macro the framing is plain 8N1 and parity_error is tied low.
module uart_rx_monitor #(
  parameter int CLK_HZ   = 50000000,
  parameter int BAUDRATE = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_error,
  output logic        parity_error,
  output logic        busy,
  output logic [15:0] byte_count
);

  localparam int DIV   = CLK_HZ / BAUDRATE;
  localparam int HALF  = DIV / 2;
  // The bit-period counter only has to reach DIV-1.
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  // A divider below 2 leaves no room for a mid-bit sample.
  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_rx_monitor: CLK_HZ/BAUDRATE must be at least 2");
    end
  endgenerate

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_e;

  // Even parity: the data bits together with the parity bit must XOR to zero.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ~(^{data, par});
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4,
    BREAK = 3'd5
  } state_e;
`endif

  state_e           state_q;
  logic             sync1_q;
  logic             rx_s_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q;
  logic             frame_error_q;
  logic             busy_q;
  logic [15:0]      byte_count_q;
`ifdef UART_RX_PARITY_EN
  logic             par_q;
  logic             parity_error_q;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level so that a line held
  // low during reset is not mistaken for a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      rx_s_q  <= sync1_q;
    end
  end

  // Receive FSM: start-bit qualification, bit sampling, stop/parity checks and
  // registered result flags (each flag is a single-cycle pulse).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      bit_cnt_q      <= 3'd0;
      shift_q        <= 8'h00;
      rx_data_q      <= 8'h00;
      rx_valid_q     <= 1'b0;
      frame_error_q  <= 1'b0;
      busy_q         <= 1'b0;
      byte_count_q   <= 16'h0000;
`ifdef UART_RX_PARITY_EN
      par_q          <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      // Flags default low so every pulse lasts exactly one cycle.
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end

        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q     <= '0;
            bit_cnt_q <= 3'd0;
            if (rx_s_q) begin
              // Line bounced back high before mid start bit: ignore it.
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              state_q <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q   <= '0;
            par_q   <= rx_s_q;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif

        STOP: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q     <= '0;
            rx_data_q <= shift_q;
            if (rx_s_q) begin
              // Return to IDLE now so a start bit right after the stop bit is caught.
              state_q <= IDLE;
              busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (parity_ok(shift_q, par_q)) begin
                rx_valid_q   <= 1'b1;
                byte_count_q <= byte_count_q + 16'd1;
              end else begin
                parity_error_q <= 1'b1;
              end
`else
              rx_valid_q   <= 1'b1;
              byte_count_q <= byte_count_q + 16'd1;
`endif
            end else begin
              frame_error_q <= 1'b1;
              state_q       <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        BREAK: begin
          // A line held low must go high again before a new frame can start.
          cnt_q <= '0;
          if (rx_s_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= BREAK;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;
  assign byte_count  = byte_count_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error = parity_error_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Testbench for uart_rx_monitor: one instance at DIV=2 and one at DIV=16.
// Table-driven frames on the fast instance, hand-written corner cases on the slow one.
module tb_uart_rx_monitor;

  localparam int CLK_HZ    = 50000000;
  localparam int BAUD_FAST = 25000000;  // DIV = 2
  localparam int BAUD_SLOW = 3125000;   // DIV = 16
  localparam int DIV_F = 2;
  localparam int HALF_F = 1;
  localparam int DIV_S = 16;
  localparam int HALF_S = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int LAT_F = 2 + HALF_F + (9 + PAR_BITS) * DIV_F + 1;
  localparam int LAT_S = 2 + HALF_S + (9 + PAR_BITS) * DIV_S + 1;

  localparam int EV_VALID  = 0;
  localparam int EV_FRAME  = 1;
  localparam int EV_PARITY = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        line_f = 1'b0;
  logic        line_s = 1'b0;
  logic [7:0]  rx_data_f, rx_data_s;
  logic        rx_valid_f, rx_valid_s;
  logic        frame_error_f, frame_error_s;
  logic        parity_error_f, parity_error_s;
  logic        busy_f, busy_s;
  logic [15:0] byte_count_f, byte_count_s;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;
  ev_t q_f[$];
  ev_t q_s[$];

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         gap;
    int         exp_kind;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs[6];
  int   starts[6];

  uart_rx_monitor #(.CLK_HZ(CLK_HZ), .BAUDRATE(BAUD_FAST)) dut_f (
    .clk(clk), .reset(reset), .uart_rx(line_f),
    .rx_data(rx_data_f), .rx_valid(rx_valid_f), .frame_error(frame_error_f),
    .parity_error(parity_error_f), .busy(busy_f), .byte_count(byte_count_f)
  );

  uart_rx_monitor #(.CLK_HZ(CLK_HZ), .BAUDRATE(BAUD_SLOW)) dut_s (
    .clk(clk), .reset(reset), .uart_rx(line_s),
    .rx_data(rx_data_s), .rx_valid(rx_valid_s), .frame_error(frame_error_s),
    .parity_error(parity_error_s), .busy(busy_s), .byte_count(byte_count_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every flag sample on the falling edge; a 2-cycle pulse shows up as two events.
  always @(negedge clk) begin
    if (rx_valid_f)     q_f.push_back('{kind: EV_VALID,  data: rx_data_f, cyc: cyc});
    if (frame_error_f)  q_f.push_back('{kind: EV_FRAME,  data: rx_data_f, cyc: cyc});
    if (parity_error_f) q_f.push_back('{kind: EV_PARITY, data: rx_data_f, cyc: cyc});
    if (rx_valid_s)     q_s.push_back('{kind: EV_VALID,  data: rx_data_s, cyc: cyc});
    if (frame_error_s)  q_s.push_back('{kind: EV_FRAME,  data: rx_data_s, cyc: cyc});
    if (parity_error_s) q_s.push_back('{kind: EV_PARITY, data: rx_data_s, cyc: cyc});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_line(input bit slow, input logic v);
    if (slow) line_s = v;
    else      line_f = v;
  endtask

  // Drive one frame starting at a falling clock edge; the line is left at the stop level.
  task automatic send_frame(input bit slow, input logic [7:0] d, input logic stop_bit,
                            input logic flip_par, output int start_cyc);
    int div;
    div = slow ? DIV_S : DIV_F;
    set_line(slow, 1'b0);
    start_cyc = cyc;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_line(slow, d[i]);
      repeat (div) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    set_line(slow, (^d) ^ flip_par);
    repeat (div) @(negedge clk);
`else
    if (flip_par) $display("[TB] note: parity bit requested in 8N1 build, not sent");
`endif
    set_line(slow, stop_bit);
    repeat (div) @(negedge clk);
  endtask

  // Wait (bounded) until at least n events are logged, then require exactly n.
  task automatic wait_events(input bit slow, input int n, input int budget, input string name);
    int k;
    k = 0;
    while (((slow ? q_s.size() : q_f.size()) < n) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    check(name, slow ? q_s.size() : q_f.size(), n);
  endtask

  task automatic check_ev(input bit slow, input string name, input int exp_kind,
                          input logic [7:0] exp_data, input int start_cyc, input int lat);
    ev_t e;
    if ((slow ? q_s.size() : q_f.size()) == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got no event, expected kind %0d data 0x%0h", name, exp_kind, exp_data);
    end else begin
      if (slow) e = q_s.pop_front();
      else      e = q_f.pop_front();
      check({name, "_kind"}, e.kind, exp_kind);
      check({name, "_data"}, int'(e.data), int'(exp_data));
      check({name, "_latency"}, e.cyc - start_cyc, lat);
    end
  endtask

  initial begin
    int st;
    int exp_count;
    bit saw_busy;

    vecs[0] = '{data: 8'h55, stop_bit: 1'b1, gap: 4, exp_kind: EV_VALID, exp_data: 8'h55};
    vecs[1] = '{data: 8'h00, stop_bit: 1'b1, gap: 0, exp_kind: EV_VALID, exp_data: 8'h00};
    vecs[2] = '{data: 8'hFF, stop_bit: 1'b1, gap: 0, exp_kind: EV_VALID, exp_data: 8'hFF};
    vecs[3] = '{data: 8'hA5, stop_bit: 1'b1, gap: 4, exp_kind: EV_VALID, exp_data: 8'hA5};
    vecs[4] = '{data: 8'h3C, stop_bit: 1'b0, gap: 6, exp_kind: EV_FRAME, exp_data: 8'h3C};
    vecs[5] = '{data: 8'h12, stop_bit: 1'b1, gap: 4, exp_kind: EV_VALID, exp_data: 8'h12};

    // Reset held 4 cycles with both lines low.
    reset = 1'b1;
    line_f = 1'b0;
    line_s = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_rx_data",  int'(rx_data_f), 0);
    check("rst_rx_valid", int'(rx_valid_f), 0);
    check("rst_frame",    int'(frame_error_f), 0);
    check("rst_parity",   int'(parity_error_f), 0);
    check("rst_busy",     int'(busy_f), 0);
    check("rst_count",    int'(byte_count_f), 0);
    check("rst_busy_s",   int'(busy_s), 0);
    line_f = 1'b1;
    line_s = 1'b1;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_busy",   int'(busy_f), 0);
    check("post_rst_busy_s", int'(busy_s), 0);
    check("post_rst_events", q_f.size() + q_s.size(), 0);

    // Table frames on the DIV=2 instance; entries with gap 0 are back-to-back.
    for (int i = 0; i < 6; i++) begin
      send_frame(1'b0, vecs[i].data, vecs[i].stop_bit, 1'b0, starts[i]);
      set_line(1'b0, 1'b1);
      repeat (vecs[i].gap) @(negedge clk);
    end
    wait_events(1'b0, 6, 100, "fast_event_count");
    exp_count = 0;
    for (int i = 0; i < 6; i++) begin
      check_ev(1'b0, $sformatf("vec%0d", i), vecs[i].exp_kind, vecs[i].exp_data,
               starts[i], LAT_F);
      if (vecs[i].exp_kind == EV_VALID) exp_count++;
    end
    check("fast_byte_count", int'(byte_count_f), exp_count);
    check("fast_busy_idle", int'(busy_f), 0);

    // Start-bit glitch on the DIV=16 instance: 3 low cycles.
    line_s = 1'b0;
    repeat (3) @(negedge clk);
    line_s = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_s) saw_busy = 1'b1;
    end
    check("glitch_busy_rose", int'(saw_busy), 1);
    check("glitch_busy_fell", int'(busy_s), 0);
    check("glitch_no_events", q_s.size(), 0);
    check("glitch_count", int'(byte_count_s), 0);

    // Framing error with the line held low for 100 cycles, then a normal byte.
    send_frame(1'b1, 8'h3C, 1'b0, 1'b0, st);
    repeat (100) @(negedge clk);
    check("break_busy", int'(busy_s), 1);
    wait_events(1'b1, 1, 10, "break_event_count");
    check_ev(1'b1, "frame_err", EV_FRAME, 8'h3C, st, LAT_S);
    line_s = 1'b1;
    repeat (6) @(negedge clk);
    check("break_exit_busy", int'(busy_s), 0);
    send_frame(1'b1, 8'h12, 1'b1, 1'b0, st);
    wait_events(1'b1, 1, 60, "after_break_count");
    check_ev(1'b1, "after_break", EV_VALID, 8'h12, st, LAT_S);
    check("after_break_bytes", int'(byte_count_s), 1);

    // Reset in the middle of a frame (after data bit 3), then a clean 0x81.
    line_s = 1'b0;
    repeat (DIV_S) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      line_s = i[0];
      repeat (DIV_S) @(negedge clk);
    end
    reset = 1'b1;
    line_s = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_busy", int'(busy_s), 0);
    check("midrst_count", int'(byte_count_s), 0);
    send_frame(1'b1, 8'h81, 1'b1, 1'b0, st);
    wait_events(1'b1, 1, 60, "midrst_event_count");
    check_ev(1'b1, "midrst_0x81", EV_VALID, 8'h81, st, LAT_S);
    check("midrst_bytes", int'(byte_count_s), 1);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight; parity bit 0 violates even parity.
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, st);
    wait_events(1'b1, 1, 60, "par_event_count");
    check_ev(1'b1, "par_err", EV_PARITY, 8'h07, st, LAT_S);
    check("par_bytes", int'(byte_count_s), 1);
`endif

    repeat (40) @(negedge clk);
    check("no_stray_events", q_f.size() + q_s.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
